// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
//
// Operation codes, FSM state encoding and the alignment rule.
// Ports: none (package).
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    function automatic logic is_load(op_e op);
        return op <= OP_LHU;
    endfunction

    function automatic logic is_store(op_e op);
        return op >= OP_SB;
    endfunction

    // Halfword ops need an even address, word ops a multiple of four.
    function automatic logic misaligned(op_e op, logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = offset[0];
            OP_LW, OP_SW:         bad = |offset;
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU and data-memory signal bundle for the load/store unit
//
// master: CPU/memory side (drives Req, Op, ByteAddr, StoreData, MemReadData).
// slave:  load_store_unit side (drives results and memory strobes).
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              Req;
    op_e               Op;
    logic [ADDR_W+1:0] ByteAddr;
    logic [31:0]       StoreData;
    logic [31:0]       LoadData;
    logic              Done;
    logic              Stall;
    logic              AddrError;
    logic [ADDR_W+1:0] ErrAddr;
    logic [ADDR_W-1:0] MemAddress;
    logic [31:0]       MemWriteData;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       MemReadData;

    modport master (
        output Req, Op, ByteAddr, StoreData, MemReadData,
        input  LoadData, Done, Stall, AddrError, ErrAddr,
               MemAddress, MemWriteData, MemRead, MemWrite
    );

    modport slave (
        input  Req, Op, ByteAddr, StoreData, MemReadData,
        output LoadData, Done, Stall, AddrError, ErrAddr,
               MemAddress, MemWriteData, MemRead, MemWrite
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - big-endian lane select/extend and lane merge
//
// Ports:
//   op          operation code (selects byte/half and sign handling)
//   offset      byte offset within the word
//   word        word read from memory
//   store_data  register value for stores
//   load_value  extended load result
//   merge_word  word with the addressed lane replaced by store data
module lsu_align
    import lsu_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merge_word
);
    // Big-endian: offset 0 is the most significant lane, so the shift
    // is (3 - offset) bytes for bytes and (1 - offset[1]) halves.
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] byte_word;
    logic [31:0] half_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    assign byte_shift = {~offset, 3'b000};
    assign half_shift = {~offset[1], 4'b0000};
    assign byte_word  = word >> byte_shift;
    assign half_word  = word >> half_shift;
    assign sel_byte   = byte_word[7:0];
    assign sel_half   = half_word[15:0];
    assign byte_mask  = 32'h0000_00FF << byte_shift;
    assign half_mask  = 32'h0000_FFFF << half_shift;

    always_comb begin
        load_value = word;
        case (op)
            OP_LB:   load_value = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_value = {24'h0, sel_byte};
            OP_LH:   load_value = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_value = {16'h0, sel_half};
            default: load_value = word;
        endcase
    end

    always_comb begin
        merge_word = store_data;
        case (op)
            OP_SB:   merge_word = (word & ~byte_mask) | ({24'h0, store_data[7:0]} << byte_shift);
            OP_SH:   merge_word = (word & ~half_mask) | ({16'h0, store_data[15:0]} << half_shift);
            default: merge_word = store_data;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store front end to a word memory
//
// Ports:
//   Clock  single clock, posedge
//   Reset  synchronous, active-high
//   bus    lsu_if.slave: CPU request (Req/Op/ByteAddr/StoreData), results
//          (LoadData/Done/Stall/AddrError/ErrAddr) and data-memory strobes
//          (MemAddress/MemWriteData/MemRead/MemWrite, MemReadData in)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic Clock,
    input  logic Reset,
    lsu_if.slave bus
);
    state_e            state;
    logic [31:0]       merge_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W+1:0] err_q;

    logic [31:0]       load_value;
    logic [31:0]       merge_word;
    logic              bad_align;
    logic              sub_store;
    logic              accept;

    lsu_align u_align (
        .op         (bus.Op),
        .offset     (bus.ByteAddr[1:0]),
        .word       (bus.MemReadData),
        .store_data (bus.StoreData),
        .load_value (load_value),
        .merge_word (merge_word)
    );

    assign bad_align = misaligned(bus.Op, bus.ByteAddr[1:0]);
    assign sub_store = is_store(bus.Op) && (bus.Op != OP_SW);
    assign accept    = !Reset && (state == ST_IDLE) && bus.Req;
    assign bus.ErrAddr = err_q;

    // Outputs are combinational so loads complete through the memory read
    // in the same cycle; Reset masks everything so a WRITE cut short by
    // reset never reaches memory.
    always_comb begin
        bus.LoadData     = 32'h0;
        bus.Done         = 1'b0;
        bus.Stall        = 1'b0;
        bus.AddrError    = 1'b0;
        bus.MemAddress   = '0;
        bus.MemWriteData = 32'h0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        if (!Reset && state == ST_WRITE) begin
            bus.MemAddress   = addr_q;
            bus.MemWriteData = merge_q;
            bus.MemWrite     = 1'b1;
            bus.Done         = 1'b1;
        end else if (accept) begin
            bus.MemAddress = bus.ByteAddr[ADDR_W+1:2];
            if (bad_align) begin
                bus.AddrError = 1'b1;
                bus.Done      = 1'b1;
            end else if (is_load(bus.Op)) begin
                bus.MemRead  = 1'b1;
                bus.LoadData = load_value;
                bus.Done     = 1'b1;
            end else if (!sub_store) begin
                bus.MemWrite     = 1'b1;
                bus.MemWriteData = bus.StoreData;
                bus.Done         = 1'b1;
            end else begin
                bus.MemRead = 1'b1;
                bus.Stall   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_IDLE;
            merge_q <= 32'h0;
            addr_q  <= '0;
            err_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Req && bad_align) begin
                        err_q <= bus.ByteAddr;
                    end else if (bus.Req && sub_store) begin
                        merge_q <= merge_word;
                        addr_q  <= bus.ByteAddr[ADDR_W+1:2];
                        state   <= ST_WRITE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 10;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    lsu_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // Data memory with a backdoor write port for presetting words.
    logic [31:0] mem     [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
    logic        bd_we   = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    assign bus.MemReadData = mem[bus.MemAddress];

    always @(posedge Clock) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.MemWrite) mem[bus.MemAddress] <= bus.MemWriteData;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [9:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge Clock); #1;
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issue one operation starting 1 time unit after a posedge; returns at
    // the same phase with Req dropped.
    task automatic run_op(input string tag, input op_e op, input logic [11:0] addr,
                          input logic [31:0] sd, input logic [31:0] exp_load,
                          input logic exp_err, input logic exp_stall,
                          input logic [31:0] exp_word, input logic [11:0] exp_erraddr);
        bus.Req = 1'b1; bus.Op = op; bus.ByteAddr = addr; bus.StoreData = sd;
        #4;
        chk($sformatf("%s done", tag),    bus.Done, {31'h0, !exp_stall});
        chk($sformatf("%s stall", tag),   bus.Stall, {31'h0, exp_stall});
        chk($sformatf("%s adderr", tag),  bus.AddrError, {31'h0, exp_err});
        chk($sformatf("%s memread", tag), bus.MemRead,
            {31'h0, !exp_err && (is_load(op) || exp_stall)});
        chk($sformatf("%s memwrite", tag), bus.MemWrite, {31'h0, !exp_err && op == OP_SW});
        if (is_load(op) || exp_err)
            chk($sformatf("%s loaddata", tag), bus.LoadData, exp_load);
        if (op == OP_SW && !exp_err)
            chk($sformatf("%s wdata", tag), bus.MemWriteData, sd);
        @(posedge Clock); #1;
        if (exp_stall) begin
            #4;
            chk($sformatf("%s wr memwrite", tag), bus.MemWrite, 32'h1);
            chk($sformatf("%s wr done", tag),     bus.Done, 32'h1);
            chk($sformatf("%s wr stall", tag),    bus.Stall, 32'h0);
            chk($sformatf("%s wr wdata", tag),    bus.MemWriteData, exp_word);
            @(posedge Clock); #1;
        end
        bus.Req = 1'b0;
        chk($sformatf("%s erraddr", tag), bus.ErrAddr, {20'h0, exp_erraddr});
        chk($sformatf("%s memword", tag), mem[addr[11:2]], exp_word);
    endtask

    // Reference model: works on the word as an array of big-endian bytes.
    logic [11:0] ref_err = '0;

    task automatic model(input op_e op, input logic [11:0] addr, input logic [31:0] sd,
                         output logic [31:0] exp_load, output logic exp_err,
                         output logic exp_stall, output logic [31:0] exp_word);
        logic [7:0] b [4];
        int k;
        logic [31:0] w;
        w = ref_mem[addr[11:2]];
        k = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
        exp_load = 0; exp_stall = 0;
        exp_err = ((op == OP_LH || op == OP_LHU || op == OP_SH) && (k % 2 != 0)) ||
                  ((op == OP_LW || op == OP_SW) && k != 0);
        if (exp_err) begin
            ref_err = addr;
        end else begin
            case (op)
                OP_LB:  exp_load = 32'($signed(b[k]));
                OP_LBU: exp_load = {24'h0, b[k]};
                OP_LH:  exp_load = 32'($signed({b[k], b[k+1]}));
                OP_LHU: exp_load = {16'h0, b[k], b[k+1]};
                OP_LW:  exp_load = w;
                OP_SB:  begin b[k] = sd[7:0]; exp_stall = 1; end
                OP_SH:  begin b[k] = sd[15:8]; b[k+1] = sd[7:0]; exp_stall = 1; end
                OP_SW:  begin b[0] = sd[31:24]; b[1] = sd[23:16]; b[2] = sd[15:8]; b[3] = sd[7:0]; end
                default: ;
            endcase
        end
        exp_word = {b[0], b[1], b[2], b[3]};
        ref_mem[addr[11:2]] = exp_word;
    endtask

    typedef struct {
        op_e         op;
        logic [11:0] addr;
        logic [31:0] sdata;
        logic        pre_en;
        logic [31:0] pre_val;
        logic [31:0] exp_load;
        logic        exp_err;
        logic        exp_stall;
        logic [31:0] exp_word;
    } vec_t;

    function automatic vec_t mk(op_e op, logic [11:0] a, logic [31:0] sd, logic pe,
                                logic [31:0] pv, logic [31:0] el, logic ee, logic es,
                                logic [31:0] ew);
        vec_t v;
        v.op = op; v.addr = a; v.sdata = sd; v.pre_en = pe; v.pre_val = pv;
        v.exp_load = el; v.exp_err = ee; v.exp_stall = es; v.exp_word = ew;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [11:0] cur_err;
        logic [7:0]  stall_pat;
        int          cycles;
        logic [31:0] el, ew;
        logic        ee, es;
        op_e         rop;
        logic [11:0] raddr;
        logic [31:0] rsd;

        bus.Req = 0; bus.Op = OP_LB; bus.ByteAddr = '0; bus.StoreData = '0;

        // Reset: outputs quiet during and after reset.
        repeat (3) @(posedge Clock);
        #1;
        chk("rst done", bus.Done, 0);
        chk("rst memwrite", bus.MemWrite, 0);
        chk("rst memread", bus.MemRead, 0);
        chk("rst stall", bus.Stall, 0);
        Reset = 0;
        @(posedge Clock); #5;
        chk("idle done", bus.Done, 0);
        chk("idle memwrite", bus.MemWrite, 0);
        chk("idle loaddata", bus.LoadData, 0);
        chk("idle erraddr", bus.ErrAddr, 0);
        @(posedge Clock); #1;

        vecs.push_back(mk(OP_LB,  12'h00C, 0, 1, 32'h80FF7F01, 32'hFFFFFF80, 0, 0, 32'h80FF7F01));
        vecs.push_back(mk(OP_LBU, 12'h00D, 0, 0, 0,            32'h000000FF, 0, 0, 32'h80FF7F01));
        vecs.push_back(mk(OP_LH,  12'h00E, 0, 0, 0,            32'h00007F01, 0, 0, 32'h80FF7F01));
        vecs.push_back(mk(OP_LHU, 12'h00C, 0, 0, 0,            32'h000080FF, 0, 0, 32'h80FF7F01));
        vecs.push_back(mk(OP_SB,  12'h00D, 32'h000000AA, 1, 32'h11223344, 0, 0, 1, 32'h11AA3344));
        vecs.push_back(mk(OP_LW,  12'h00C, 0, 0, 0,            32'h11AA3344, 0, 0, 32'h11AA3344));
        vecs.push_back(mk(OP_SH,  12'h00E, 32'h0000BEEF, 1, 32'h0, 0, 0, 1, 32'h0000BEEF));
        vecs.push_back(mk(OP_SW,  12'h004, 32'hCAFEF00D, 1, 32'h0, 0, 0, 0, 32'hCAFEF00D));
        vecs.push_back(mk(OP_LW,  12'h006, 0, 0, 0,            0, 1, 0, 32'hCAFEF00D));
        vecs.push_back(mk(OP_SH,  12'h003, 32'h0000FFFF, 1, 32'h12345678, 0, 1, 0, 32'h12345678));
        vecs.push_back(mk(OP_SB,  12'hFFF, 32'h0000005A, 1, 32'h0, 0, 0, 1, 32'h0000005A));
        vecs.push_back(mk(OP_LBU, 12'hFFF, 0, 0, 0,            32'h0000005A, 0, 0, 32'h0000005A));
        vecs.push_back(mk(OP_LB,  12'hFFE, 0, 1, 32'h00007F00, 32'h0000007F, 0, 0, 32'h00007F00));

        cur_err = '0;
        foreach (vecs[i]) begin
            if (vecs[i].pre_en) preset(vecs[i].addr[11:2], vecs[i].pre_val);
            if (vecs[i].exp_err) cur_err = vecs[i].addr;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].sdata,
                   vecs[i].exp_load, vecs[i].exp_err, vecs[i].exp_stall,
                   vecs[i].exp_word, cur_err);
        end

        // Back-to-back SB into word 5: one store per two cycles.
        preset(10'd5, 32'h0);
        stall_pat = '0;
        cycles = 0;
        for (int i = 0; i < 4; i++) begin
            bus.Req = 1; bus.Op = OP_SB; bus.ByteAddr = {10'd5, 2'(i)};
            bus.StoreData = 32'(8'h11 * (i + 1));
            for (int c = 0; c < 2; c++) begin
                #4;
                stall_pat = {stall_pat[6:0], bus.Stall};
                if (c == 1) chk($sformatf("b2b%0d memwrite", i), bus.MemWrite, 1);
                @(posedge Clock); #1;
                cycles++;
            end
        end
        bus.Req = 0;
        chk("b2b cycles", cycles, 8);
        chk("b2b stall pattern", {24'h0, stall_pat}, 32'h000000AA);
        chk("b2b word", mem[5], 32'h11223344);

        // Reset asserted in the WRITE cycle of an SB.
        preset(10'd7, 32'h55667788);
        bus.Req = 1; bus.Op = OP_SB; bus.ByteAddr = 12'h01C; bus.StoreData = 32'h99;
        #4;
        chk("rstwr stall", bus.Stall, 1);
        @(posedge Clock); #1;
        Reset = 1;
        #4;
        chk("rstwr memwrite", bus.MemWrite, 0);
        chk("rstwr done", bus.Done, 0);
        @(posedge Clock); #1;
        Reset = 0; bus.Req = 0;
        chk("rstwr erraddr", bus.ErrAddr, 0);
        chk("rstwr word", mem[7], 32'h55667788);
        cur_err = '0;
        run_op("rstwr lw", OP_LW, 12'h01C, 0, 32'h55667788, 0, 0, 32'h55667788, cur_err);

        // Randomized operations on words 16..23 against the reference model.
        for (int w = 16; w < 24; w++) preset(10'(w), $urandom);
        ref_err = '0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.Req = 0; bus.Op = op_e'($urandom_range(0, 7));
                bus.ByteAddr = 12'($urandom);
                #4;
                chk("rnd idle done", bus.Done, 0);
                chk("rnd idle strobes", {30'h0, bus.MemRead, bus.MemWrite}, 0);
                @(posedge Clock); #1;
            end
            rop   = op_e'($urandom_range(0, 7));
            raddr = {10'($urandom_range(16, 23)), 2'($urandom_range(0, 3))};
            rsd   = $urandom;
            model(rop, raddr, rsd, el, ee, es, ew);
            run_op($sformatf("rnd%0d", n), rop, raddr, rsd, el, ee, es, ew, ref_err);
        end
        for (int w = 16; w < 24; w++)
            chk($sformatf("rnd final word %0d", w), mem[w], ref_mem[w]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the datapath (ALU address result, register-file store data) and the word-organised data memory. Translates byte/halfword/word loads and stores into whole-word memory accesses. Sub-word stores are done as a two-cycle read-modify-write with a CPU stall. Loads are sign- or zero-extended, and misaligned accesses are detected and suppressed.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the data memory (byte address is ADDR_W+2 bits)

Ports:
- Clock  in  1  single clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- Req  in  1  CPU presents a memory operation this cycle
- Op  in  3  operation code (see Structure)
- ByteAddr  in  ADDR_W+2  byte address from ALU
- StoreData  in  32  register rt value for stores
- LoadData  out  32  extended load result, valid when Done and Op is a load
- Done  out  1  operation completes this cycle
- Stall  out  1  CPU must hold PC and all Req/Op/ByteAddr/StoreData inputs
- AddrError  out  1  misaligned access, one-cycle pulse with Done
- ErrAddr  out  ADDR_W+2  byte address of the most recent misaligned access (sticky)
- MemAddress  out  ADDR_W  word address to data memory
- MemWriteData  out  32  word to write
- MemRead  out  1  read enable
- MemWrite  out  1  write enable, sampled by memory on posedge
- MemReadData  in  32  combinational read data from memory

## Operation
- Byte order is big-endian: byte offset 0 maps to bits 31:24, and halfword offset 0 maps to bits 31:16.
- MemAddress = ByteAddr[ADDR_W+1:2]. In WRITE, the latched address is used instead.
- Alignment rules:
  - LH, LHU, SH require ByteAddr[0]=0.
  - LW, SW require ByteAddr[1:0]=0.
  - Byte operations are always aligned.
- On a misaligned access: AddrError=1, Done=1, MemRead=0, MemWrite=0, LoadData=0, ErrAddr<=ByteAddr. There is no stall.
- FSM states:
  - IDLE:
    - Loads: MemRead=1, LoadData = selected byte/half, sign-extended (LB, LH) or zero-extended (LBU, LHU), or the full word (LW). Done=1 in the same cycle.
    - SW: MemWrite=1, MemWriteData=StoreData, Done=1.
    - SB/SH: MemRead=1, Stall=1. Register the merge word (MemReadData with the selected lane replaced by StoreData[7:0] or StoreData[15:0]) and the word address. Go to WRITE.
  - WRITE: MemWrite=1, MemAddress=latched address, MemWriteData=merge register, Done=1, Stall=0. Go to IDLE.
- With Req=0 in IDLE, all memory strobes and Done are 0.
- Req and Op are ignored in WRITE. The CPU holds its inputs because Stall was 1 in the previous cycle.

## Timing
- Reset values: state=IDLE, merge register=0, latched address=0, ErrAddr=0. All outputs are 0 during and after reset until Req.
- Latency:
  - Loads, SW, and misaligned accesses complete in 1 cycle (combinational through the memory read).
  - SB/SH complete in 2 cycles, with exactly one Stall cycle.
- Memory write lands at the posedge ending the cycle with MemWrite=1.
- A load issued in the cycle after an SB/SH completes observes the merged word.
- Reset asserted in WRITE: return to IDLE, no MemWrite issued, memory unchanged.
- Back-to-back SB: the second Req is accepted in the cycle after WRITE. Throughput for back-to-back SB is one store per 2 cycles.
- Highest byte address (all ones) wraps nothing. The address is only truncated to ADDR_W word bits.

## Structure
- Package lsu_pkg holds:
  - Op encoding: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
  - Helper constants is_load(op)/is_store(op) as op ranges: 0–4 are loads, 5–7 are stores.
  - FSM state encoding: IDLE=0, WRITE=1.
- One natural sub-module: lsu_align, a combinational lane-select/extend and lane-merge block shared by the load path and the merge path.

## Test plan
- Memory word 3 = 0x80FF7F01. LB at 0x0C gives LoadData=0xFFFFFF80. LBU at 0x0D gives 0x000000FF. LH at 0x0E gives 0x00007F01. Done=1 and Stall=0 in each case.
- SB StoreData=0x000000AA at 0x0D on word 0x11223344:
  - Cycle 1: Stall=1, MemRead=1, MemWrite=0.
  - Cycle 2: MemWrite=1, MemWriteData=0x11AA3344, Done=1.
  - A following LW at 0x0C gives 0x11AA3344.
- SH 0xBEEF at 0x0E on word 0 (0x00000000): write 0x0000BEEF. Then SW 0xCAFEF00D to 0x04 completes in one cycle with Stall never asserted.
- LW at 0x06 and SH at 0x03:
  - Each gives AddrError=1 and Done=1, with MemWrite=0 and MemRead=0.
  - ErrAddr=0x006, then 0x003.
  - Target words are unchanged.
- Reset asserted during the WRITE cycle of an SB: no MemWrite, state=IDLE, ErrAddr=0, and the target word still holds its original value.
- Back-to-back SB to offsets 0, 1, 2, 3 of word 5 with StoreData 0x11, 0x22, 0x33, 0x44: 8 cycles, Stall pattern 1,0,1,0,1,0,1,0, final word 0x11223344.
